// File: rtl/rf_write_sequencer_if.sv
// Write-back request/issue bundle between the pipeline sources and the
// register-file write sequencer.
interface rf_write_sequencer_if #(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic            WV0;
    logic [3:0]      WD0;
    logic [31:0]     WP0;
    logic            WR0;
    logic            WV1;
    logic [3:0]      WD1;
    logic [31:0]     WP1;
    logic            WR1;
    logic            HOLD;
    logic            FLUSH;
    logic [3:0]      C;
    logic [31:0]     PW;
    logic            RFLd;
    logic [15:0]     PEND;
    logic [CNTW-1:0] CNT;

    // Pipeline / register-file side.
    modport master (
        output WV0, WD0, WP0, WV1, WD1, WP1, HOLD, FLUSH,
        input  WR0, WR1, C, PW, RFLd, PEND, CNT
    );

    // Sequencer side.
    modport slave (
        input  WV0, WD0, WP0, WV1, WD1, WP1, HOLD, FLUSH,
        output WR0, WR1, C, PW, RFLd, PEND, CNT
    );
endinterface

// File: rtl/rf_write_sequencer.sv
// Register-file write sequencer: merges two write-back sources into an
// in-order FIFO and issues at most one register write per clock.
module rf_write_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input logic                  CLK,
    input logic                  RST_N,
    rf_write_sequencer_if.slave  bus
);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] DEPTH_M1 = CNTW'(DEPTH - 1);

    logic [3:0]      dest_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr1;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [3:0]      c_q, c_d;
    logic [31:0]     pw_q, pw_d;
    logic            rfld_q, rfld_d;
    logic            wr0, wr1, acc0, acc1, pop;
    logic [15:0]     pend;
    logic [PTRW-1:0] off;

    // Handshake and pop decisions; ready looks only at the registered count.
    always_comb begin
        wr0  = (cnt_q < DEPTH_C) && !bus.FLUSH;
        wr1  = ((cnt_q < DEPTH_M1) || ((cnt_q < DEPTH_C) && !bus.WV0)) && !bus.FLUSH;
        acc0 = bus.WV0 && wr0;
        acc1 = bus.WV1 && wr1;
        pop  = !bus.FLUSH && !bus.HOLD && (cnt_q != '0);
    end

    // Next-state for pointers, occupancy and the issue registers.
    always_comb begin
        wr_ptr1  = acc0 ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        pw_d     = pw_q;
        rfld_d   = 1'b0;
        if (bus.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop) begin
                c_d      = dest_q[rd_ptr_q];
                pw_d     = data_q[rd_ptr_q];
                rfld_d   = 1'b1;
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            wr_ptr_d = wr_ptr_q + PTRW'(acc0) + PTRW'(acc1);
            cnt_d    = cnt_q + CNTW'(acc0) + CNTW'(acc1) - CNTW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            c_q      <= '0;
            pw_q     <= '0;
            rfld_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            pw_q     <= pw_d;
            rfld_q   <= rfld_d;
        end
    end

    // FIFO storage; source 0 lands ahead of source 1 on a dual accept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                dest_q[j] <= '0;
                data_q[j] <= '0;
            end
        end else begin
            if (acc0) begin
                dest_q[wr_ptr_q] <= bus.WD0;
                data_q[wr_ptr_q] <= bus.WP0;
            end
            if (acc1) begin
                dest_q[wr_ptr1] <= bus.WD1;
                data_q[wr_ptr1] <= bus.WP1;
            end
        end
    end

    // Pending mask: live FIFO slots (offset from head below count) plus the
    // write currently presented to the register file.
    always_comb begin
        pend = '0;
        off  = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            off = PTRW'(j) - rd_ptr_q;
            if ({1'b0, off} < cnt_q) begin
                pend[dest_q[j]] = 1'b1;
            end
        end
        if (rfld_q) begin
            pend[c_q] = 1'b1;
        end
    end

    assign bus.WR0  = wr0;
    assign bus.WR1  = wr1;
    assign bus.C    = c_q;
    assign bus.PW   = pw_q;
    assign bus.RFLd = rfld_q;
    assign bus.PEND = pend;
    assign bus.CNT  = cnt_q;
endmodule

// File: tb/tb_rf_write_sequencer.sv
// Scoreboard bench for rf_write_sequencer.
module tb_rf_write_sequencer;
    localparam int DEPTH = 4;

    logic CLK;
    logic RST_N;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [35:0] sb[$];
    logic        exp_rfld;
    logic [3:0]  exp_c;
    logic [31:0] exp_pw;

    rf_write_sequencer_if #(.DEPTH(DEPTH)) bus ();

    rf_write_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge), update the
    // model, then check outputs at the next falling edge.
    task automatic cycle(input logic v0, input logic [3:0] d0, input logic [31:0] p0,
                         input logic v1, input logic [3:0] d1, input logic [31:0] p1,
                         input logic hold, input logic flush);
        logic        ew0, ew1;
        logic [15:0] ep;
        bus.WV0 = v0; bus.WD0 = d0; bus.WP0 = p0;
        bus.WV1 = v1; bus.WD1 = d1; bus.WP1 = p1;
        bus.HOLD = hold; bus.FLUSH = flush;
        #1;
        ew0 = (sb.size() < DEPTH) && !flush;
        ew1 = ((sb.size() < DEPTH - 1) || ((sb.size() < DEPTH) && !v0)) && !flush;
        check_eq("wr0", 32'(bus.WR0), 32'(ew0));
        check_eq("wr1", 32'(bus.WR1), 32'(ew1));
        if (flush) begin
            sb.delete();
            exp_rfld = 1'b0;
        end else begin
            if (!hold && sb.size() > 0) begin
                {exp_c, exp_pw} = sb.pop_front();
                exp_rfld = 1'b1;
            end else begin
                exp_rfld = 1'b0;
            end
            if (v0 && ew0) sb.push_back({d0, p0});
            if (v1 && ew1) sb.push_back({d1, p1});
        end
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rfld", 32'(bus.RFLd), 32'(exp_rfld));
        if (bus.RFLd) begin
            check_eq("c", 32'(bus.C), 32'(exp_c));
            check_eq("pw", bus.PW, exp_pw);
        end
        ep = '0;
        foreach (sb[i]) ep[sb[i][35:32]] = 1'b1;
        if (exp_rfld) ep[exp_c] = 1'b1;
        check_eq("pend", 32'(bus.PEND), 32'(ep));
        check_eq("cnt", 32'(bus.CNT), 32'(sb.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RST_N = 1'b0;
        exp_rfld = 1'b0; exp_c = '0; exp_pw = '0;
        bus.WV0 = 0; bus.WD0 = 0; bus.WP0 = 0;
        bus.WV1 = 0; bus.WD1 = 0; bus.WP1 = 0;
        bus.HOLD = 0; bus.FLUSH = 0;
        repeat (2) @(negedge CLK);
        check_eq("rst_rfld", 32'(bus.RFLd), 0);
        check_eq("rst_c", 32'(bus.C), 0);
        check_eq("rst_pw", bus.PW, 0);
        check_eq("rst_pend", 32'(bus.PEND), 0);
        check_eq("rst_cnt", 32'(bus.CNT), 0);
        check_eq("rst_wr0", 32'(bus.WR0), 1);
        check_eq("rst_wr1", 32'(bus.WR1), 1);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single write: latency and PEND window.
        cycle(1, 4'd10, 32'd16, 0, 0, 0, 0, 0);
        check_eq("single_pend10_a", 32'(bus.PEND[10]), 1);
        idle(1);
        check_eq("single_c", 32'(bus.C), 10);
        idle(1);
        check_eq("single_pend10_c", 32'(bus.PEND[10]), 0);

        // Dual accept to the same register: source 0 first, then source 1.
        cycle(1, 4'd3, 32'd90, 1, 4'd3, 32'd7, 0, 0);
        idle(3);
        check_eq("dual_last_pw", bus.PW, 7);

        // Fill under HOLD, including a dual request at CNT = 3.
        for (int i = 0; i < 3; i++) cycle(1, 4'(i + 1), 32'(100 + i), 0, 0, 0, 1, 0);
        cycle(1, 4'd4, 32'd103, 1, 4'd9, 32'd999, 1, 0);
        cycle(1, 4'd5, 32'd104, 0, 0, 0, 1, 0);
        check_eq("full_cnt", 32'(bus.CNT), 4);
        idle(5);

        // HOLD for two cycles in the middle of a three-entry drain.
        cycle(1, 4'd6, 32'd200, 1, 4'd7, 32'd201, 1, 0);
        cycle(1, 4'd8, 32'd202, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);

        // Flush with CNT = 2 and a concurrent request.
        cycle(1, 4'd11, 32'd300, 1, 4'd12, 32'd301, 1, 0);
        cycle(1, 4'd13, 32'd302, 0, 0, 0, 0, 1);
        check_eq("flush_cnt", 32'(bus.CNT), 0);
        idle(2);

        // Asynchronous reset mid-stream with CNT = 3.
        cycle(1, 4'd1, 32'd400, 1, 4'd2, 32'd401, 1, 0);
        cycle(1, 4'd14, 32'd402, 0, 0, 0, 1, 0);
        bus.WV0 = 1; bus.WV1 = 1; bus.HOLD = 0;
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("mrst_rfld", 32'(bus.RFLd), 0);
        check_eq("mrst_pend", 32'(bus.PEND), 0);
        check_eq("mrst_cnt", 32'(bus.CNT), 0);
        check_eq("mrst_wr0", 32'(bus.WR0), 1);
        check_eq("mrst_wr1", 32'(bus.WR1), 1);
        sb.delete();
        exp_rfld = 1'b0;
        exp_c = '0;
        exp_pw = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        idle(3);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
